// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler: FSM state encoding and the far-depth clear value.
package frame_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        DRAW      = 3'd2,
        DRAIN     = 3'd3,
        WAIT_SWAP = 3'd4
    } state_t;

    // Wide all-ones value; truncating it to any depth width yields the farthest depth.
    localparam int unsigned FAR_DEPTH_MAX_WIDTH = 64;
    localparam logic [FAR_DEPTH_MAX_WIDTH-1:0] FAR_DEPTH = '1;

endpackage

// File: rtl/frame_scheduler_clear_counter.sv
// Loadable up-counter that saturates at a run-time terminal value; drives the clear sweep and the drain count.
module clear_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             done_c
);

    assign done_c = (count == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && !done_c) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer in front of depth_writer: clear, draw, drain, swap on vsync.
// Optional macro FRAME_OVERRUN_EN enables the sticky overrun flag for ignored frame starts.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned FB_ADDR_WIDTH   = 17,
    parameter int unsigned FB_BIT_WIDTH    = 16,
    parameter int unsigned DEPTH_BIT_WIDTH = 16,
    parameter int unsigned FB_SIZE         = 57600,
    parameter logic [FB_BIT_WIDTH-1:0] CLEAR_COLOR = '0,
    parameter int unsigned PIPE_DEPTH      = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       frame_start_in,
    input  logic                       vsync_in,
    input  logic                       raster_valid_in,
    input  logic [FB_ADDR_WIDTH-1:0]   raster_addr_in,
    input  logic [FB_BIT_WIDTH-1:0]    raster_color_in,
    input  logic [DEPTH_BIT_WIDTH-1:0] raster_depth_in,
    input  logic                       raster_done_in,
    output logic                       raster_ready_out,
    output logic                       raster_start_out,
    output logic                       drawing_out,
    output logic                       fb_we_out,
    output logic                       dp_we_out,
    output logic                       dp_re_out,
    output logic                       fb_front_out,
    output logic [FB_ADDR_WIDTH-1:0]   fb_write_out,
    output logic [FB_ADDR_WIDTH-1:0]   dp_write_out,
    output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
    output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
    output logic                       display_sel_out,
    output logic                       busy_out,
    output logic                       frame_done_out,
    output logic                       overrun_out
);

    localparam int unsigned CLR_W = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
    localparam int unsigned DRN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int unsigned CNT_W = (CLR_W > DRN_W) ? CLR_W : DRN_W;
    localparam logic [DEPTH_BIT_WIDTH-1:0] FAR = DEPTH_BIT_WIDTH'(FAR_DEPTH);

    state_t state, state_next;

    logic                       cnt_load;
    logic [CNT_W-1:0]           cnt_load_value;
    logic                       cnt_en;
    logic [CNT_W-1:0]           cnt_term;
    logic [CNT_W-1:0]           cnt;
    logic                       cnt_done;

    logic                       wr_next;
    logic                       drawing_next;
    logic                       dp_re_next;
    logic [FB_ADDR_WIDTH-1:0]   addr_next;
    logic [FB_BIT_WIDTH-1:0]    color_next;
    logic [DEPTH_BIT_WIDTH-1:0] depth_next;
    logic                       ready_next;
    logic                       start_next;
    logic                       frame_done_next;

    clear_counter #(.WIDTH(CNT_W)) u_counter (
        .clk        (clk_in),
        .rst        (rst_in),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .en         (cnt_en),
        .term       (cnt_term),
        .count      (cnt),
        .done_c     (cnt_done)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the values the output registers take at this edge.
    always_comb begin
        state_next      = state;
        cnt_load        = 1'b0;
        cnt_load_value  = '0;
        cnt_en          = 1'b0;
        cnt_term        = CNT_W'(FB_SIZE - 1);
        wr_next         = 1'b0;
        drawing_next    = 1'b0;
        dp_re_next      = 1'b0;
        addr_next       = '0;
        color_next      = '0;
        depth_next      = '0;
        ready_next      = 1'b0;
        start_next      = 1'b0;
        frame_done_next = 1'b0;

        case (state)
            IDLE: begin
                // Address 0 is issued on the accepting edge; the counter resumes from 1.
                if (frame_start_in) begin
                    state_next     = CLEAR;
                    wr_next        = 1'b1;
                    color_next     = CLEAR_COLOR;
                    depth_next     = FAR;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(1);
                end
            end
            CLEAR: begin
                wr_next    = 1'b1;
                addr_next  = FB_ADDR_WIDTH'(cnt);
                color_next = CLEAR_COLOR;
                depth_next = FAR;
                cnt_en     = 1'b1;
                if (cnt_done) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                ready_next = !raster_done_in;
                start_next = !raster_ready_out;
                if (raster_valid_in && raster_ready_out) begin
                    wr_next      = 1'b1;
                    drawing_next = 1'b1;
                    dp_re_next   = 1'b1;
                    addr_next    = raster_addr_in;
                    color_next   = raster_color_in;
                    depth_next   = raster_depth_in;
                end
                if (raster_done_in) begin
                    state_next = DRAIN;
                    cnt_load   = 1'b1;
                end
            end
            DRAIN: begin
                cnt_term = CNT_W'(PIPE_DEPTH - 1);
                cnt_en   = 1'b1;
                if (cnt_done) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (vsync_in) begin
                    frame_done_next = 1'b1;
                    if (frame_start_in) begin
                        state_next = CLEAR;
                        cnt_load   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            raster_ready_out <= 1'b0;
            raster_start_out <= 1'b0;
            drawing_out      <= 1'b0;
            fb_we_out        <= 1'b0;
            dp_we_out        <= 1'b0;
            dp_re_out        <= 1'b0;
            fb_front_out     <= 1'b0;
            fb_write_out     <= '0;
            dp_write_out     <= '0;
            fb_value_out     <= '0;
            dp_value_out     <= '0;
            display_sel_out  <= 1'b0;
            busy_out         <= 1'b0;
            frame_done_out   <= 1'b0;
        end else begin
            raster_ready_out <= ready_next;
            raster_start_out <= start_next;
            drawing_out      <= drawing_next;
            fb_we_out        <= wr_next;
            dp_we_out        <= wr_next;
            dp_re_out        <= dp_re_next;
            fb_front_out     <= wr_next & ~display_sel_out;
            fb_write_out     <= addr_next;
            dp_write_out     <= addr_next;
            fb_value_out     <= color_next;
            dp_value_out     <= depth_next;
            display_sel_out  <= display_sel_out ^ frame_done_next;
            busy_out         <= (state_next != IDLE);
            frame_done_out   <= frame_done_next;
        end
    end

`ifdef FRAME_OVERRUN_EN
    logic ignored_start;

    assign ignored_start = frame_start_in &&
                           ((state == CLEAR) || (state == DRAW) || (state == DRAIN) ||
                            ((state == WAIT_SWAP) && !vsync_in));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overrun_out <= 1'b0;
        end else if (ignored_start) begin
            overrun_out <= 1'b1;
        end
    end
`else
    assign overrun_out = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with FB_SIZE=16, PIPE_DEPTH=4; each vector is one clock of stimulus plus expected outputs.
module tb_frame_scheduler;

    localparam int unsigned AW = 17;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          vsync;
    logic          raster_valid;
    logic [AW-1:0] raster_addr;
    logic [CW-1:0] raster_color;
    logic [DW-1:0] raster_depth;
    logic          raster_done;
    logic          raster_ready;
    logic          raster_start;
    logic          drawing;
    logic          fb_we;
    logic          dp_we;
    logic          dp_re;
    logic          fb_front;
    logic [AW-1:0] fb_write;
    logic [AW-1:0] dp_write;
    logic [CW-1:0] fb_value;
    logic [DW-1:0] dp_value;
    logic          display_sel;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    frame_scheduler #(
        .FB_ADDR_WIDTH   (AW),
        .FB_BIT_WIDTH    (CW),
        .DEPTH_BIT_WIDTH (DW),
        .FB_SIZE         (16),
        .CLEAR_COLOR     (16'h0000),
        .PIPE_DEPTH      (4)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .frame_start_in   (frame_start),
        .vsync_in         (vsync),
        .raster_valid_in  (raster_valid),
        .raster_addr_in   (raster_addr),
        .raster_color_in  (raster_color),
        .raster_depth_in  (raster_depth),
        .raster_done_in   (raster_done),
        .raster_ready_out (raster_ready),
        .raster_start_out (raster_start),
        .drawing_out      (drawing),
        .fb_we_out        (fb_we),
        .dp_we_out        (dp_we),
        .dp_re_out        (dp_re),
        .fb_front_out     (fb_front),
        .fb_write_out     (fb_write),
        .dp_write_out     (dp_write),
        .fb_value_out     (fb_value),
        .dp_value_out     (dp_value),
        .display_sel_out  (display_sel),
        .busy_out         (busy),
        .frame_done_out   (frame_done),
        .overrun_out      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          busy;
        logic          ready;
        logic          start;
        logic          drawing;
        logic          fb_we;
        logic          dp_we;
        logic          dp_re;
        logic          front;
        logic          sel;
        logic          done;
        logic          overrun;
        logic [AW-1:0] fb_addr;
        logic [AW-1:0] dp_addr;
        logic [CW-1:0] color;
        logic [DW-1:0] depth;
    } out_t;

    typedef struct packed {
        logic          rst;
        logic          fs;
        logic          vs;
        logic          valid;
        logic          done;
        logic          ign;
        logic [AW-1:0] addr;
        logic [CW-1:0] color;
        logic [DW-1:0] depth;
        out_t          exp;
    } vec_t;

    int   checks;
    int   errors;
    int   step;
    logic ovr_model;

    function automatic out_t o_none(input logic b, input logic r, input logic s);
        out_t o;
        o       = '0;
        o.busy  = b;
        o.ready = r;
        o.sel   = s;
        return o;
    endfunction

    function automatic out_t o_clear(input int unsigned a, input logic s);
        out_t o;
        o         = o_none(1'b1, 1'b0, s);
        o.fb_we   = 1'b1;
        o.dp_we   = 1'b1;
        o.front   = ~s;
        o.fb_addr = AW'(a);
        o.dp_addr = AW'(a);
        o.color   = 16'h0000;
        o.depth   = 16'hFFFF;
        return o;
    endfunction

    function automatic out_t o_pix(input logic [AW-1:0] a, input logic [CW-1:0] c,
                                   input logic [DW-1:0] d, input logic s, input logic r);
        out_t o;
        o         = o_none(1'b1, r, s);
        o.drawing = 1'b1;
        o.fb_we   = 1'b1;
        o.dp_we   = 1'b1;
        o.dp_re   = 1'b1;
        o.front   = ~s;
        o.fb_addr = a;
        o.dp_addr = a;
        o.color   = c;
        o.depth   = d;
        return o;
    endfunction

    function automatic vec_t idle_vec(input out_t e);
        vec_t v;
        v     = '0;
        v.exp = e;
        return v;
    endfunction

    function automatic vec_t ctl_vec(input logic fs, input logic vs, input logic ign, input out_t e);
        vec_t v;
        v     = idle_vec(e);
        v.fs  = fs;
        v.vs  = vs;
        v.ign = ign;
        return v;
    endfunction

    function automatic vec_t pix_vec(input logic [AW-1:0] a, input logic [CW-1:0] c,
                                     input logic [DW-1:0] d, input logic dn, input out_t e);
        vec_t v;
        v       = idle_vec(e);
        v.valid = 1'b1;
        v.addr  = a;
        v.color = c;
        v.depth = d;
        v.done  = dn;
        return v;
    endfunction

    function automatic logic [10:0] flags(input out_t o);
        return {o.busy, o.ready, o.start, o.drawing, o.fb_we, o.dp_we, o.dp_re,
                o.front, o.sel, o.done, o.overrun};
    endfunction

    // Drive one cycle of inputs, let the edge happen, then compare just after it.
    task automatic apply(input vec_t v);
        out_t act;
        out_t exp;
        rst          = v.rst;
        frame_start  = v.fs;
        vsync        = v.vs;
        raster_valid = v.valid;
        raster_addr  = v.addr;
        raster_color = v.color;
        raster_depth = v.depth;
        raster_done  = v.done;
        @(posedge clk);
        #1;
        if (v.rst) ovr_model = 1'b0;
`ifdef FRAME_OVERRUN_EN
        if (v.ign && !v.rst) ovr_model = 1'b1;
`endif
        act.busy    = busy;
        act.ready   = raster_ready;
        act.start   = raster_start;
        act.drawing = drawing;
        act.fb_we   = fb_we;
        act.dp_we   = dp_we;
        act.dp_re   = dp_re;
        act.front   = fb_front;
        act.sel     = display_sel;
        act.done    = frame_done;
        act.overrun = overrun;
        act.fb_addr = fb_write;
        act.dp_addr = dp_write;
        act.color   = fb_value;
        act.depth   = dp_value;
        exp         = v.exp;
        exp.overrun = ovr_model;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d busy/rdy/start/draw/fbwe/dpwe/re/front/sel/done/ovr got %b addr %h/%h col %h dep %h, expected %b addr %h/%h col %h dep %h",
                     step, flags(act), act.fb_addr, act.dp_addr, act.color, act.depth,
                     flags(exp), exp.fb_addr, exp.dp_addr, exp.color, exp.depth);
        end
        step++;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        out_t o;

        // Frame 1 draw, drain and swap; entered right after the raster_start cycle.
        tbl.push_back(pix_vec(17'd3, 16'h1111, 16'h0100, 1'b0, o_pix(17'd3, 16'h1111, 16'h0100, 1'b0, 1'b1)));
        tbl.push_back(idle_vec(o_none(1'b1, 1'b1, 1'b0)));
        tbl.push_back(pix_vec(17'd7, 16'h2222, 16'h0200, 1'b0, o_pix(17'd7, 16'h2222, 16'h0200, 1'b0, 1'b1)));
        tbl.push_back(ctl_vec(1'b1, 1'b0, 1'b1, o_none(1'b1, 1'b1, 1'b0)));
        tbl.push_back(pix_vec(17'd3, 16'h3333, 16'h0080, 1'b1, o_pix(17'd3, 16'h3333, 16'h0080, 1'b0, 1'b0)));
        tbl.push_back(pix_vec(17'd9, 16'h4444, 16'h0010, 1'b0, o_none(1'b1, 1'b0, 1'b0)));
        tbl.push_back(idle_vec(o_none(1'b1, 1'b0, 1'b0)));
        tbl.push_back(idle_vec(o_none(1'b1, 1'b0, 1'b0)));
        tbl.push_back(ctl_vec(1'b0, 1'b1, 1'b0, o_none(1'b1, 1'b0, 1'b0)));
        o      = o_none(1'b0, 1'b0, 1'b1);
        o.done = 1'b1;
        tbl.push_back(ctl_vec(1'b0, 1'b1, 1'b0, o));
        tbl.push_back(idle_vec(o_none(1'b0, 1'b0, 1'b1)));
        tbl.push_back(ctl_vec(1'b0, 1'b1, 1'b0, o_none(1'b0, 1'b0, 1'b1)));

        checks       = 0;
        errors       = 0;
        step         = 0;
        ovr_model    = 1'b0;
        rst          = 1'b1;
        frame_start  = 1'b0;
        vsync        = 1'b0;
        raster_valid = 1'b0;
        raster_addr  = '0;
        raster_color = '0;
        raster_depth = '0;
        raster_done  = 1'b0;

        v     = idle_vec(o_none(1'b0, 1'b0, 1'b0));
        v.rst = 1'b1;
        apply(v);
        apply(v);
        apply(idle_vec(o_none(1'b0, 1'b0, 1'b0)));
        apply(ctl_vec(1'b0, 1'b1, 1'b0, o_none(1'b0, 1'b0, 1'b0)));

        // Frame 1 clear into back buffer 1.
        apply(ctl_vec(1'b1, 1'b0, 1'b0, o_clear(0, 1'b0)));
        for (int k = 1; k < 16; k++) apply(idle_vec(o_clear(k, 1'b0)));
        o       = o_none(1'b1, 1'b1, 1'b0);
        o.start = 1'b1;
        apply(idle_vec(o));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Frame 2: clear into buffer 0, empty draw, then vsync with a simultaneous start.
        apply(ctl_vec(1'b1, 1'b0, 1'b0, o_clear(0, 1'b1)));
        for (int k = 1; k < 16; k++) apply(idle_vec(o_clear(k, 1'b1)));
        o       = o_none(1'b1, 1'b1, 1'b1);
        o.start = 1'b1;
        apply(idle_vec(o));
        v      = idle_vec(o_none(1'b1, 1'b0, 1'b1));
        v.done = 1'b1;
        apply(v);
        repeat (3) apply(idle_vec(o_none(1'b1, 1'b0, 1'b1)));
        apply(ctl_vec(1'b1, 1'b0, 1'b1, o_none(1'b1, 1'b0, 1'b1)));
        o      = o_none(1'b1, 1'b0, 1'b0);
        o.done = 1'b1;
        apply(ctl_vec(1'b1, 1'b1, 1'b0, o));
        for (int k = 0; k < 5; k++) apply(idle_vec(o_clear(k, 1'b0)));

        // Reset where address 5 would be issued.
        v     = idle_vec(o_none(1'b0, 1'b0, 1'b0));
        v.rst = 1'b1;
        apply(v);
        repeat (3) apply(idle_vec(o_none(1'b0, 1'b0, 1'b0)));
        apply(ctl_vec(1'b1, 1'b0, 1'b0, o_clear(0, 1'b0)));
        apply(idle_vec(o_clear(1, 1'b0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
